// File: rtl/sprite_row_fetch.sv
// Sprite row read sequencer: issues a ROW_W-word burst to the sprite RAM, tracks its read
// latency and hands each returned word to the pixel registers. Optional mirroring: SPRITE_FETCH_MIRROR_EN.
module sprite_row_fetch #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int PIX_W    = 4,
  parameter int ROW_W    = 4,
  parameter int ROWSEL_W = 4,
  parameter int RD_LAT   = 2,
  parameter int IDX_W    = 2
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Start,
  input  logic [ADDR_W-1:0]   SpriteBase,
  input  logic [ROWSEL_W-1:0] Row,
  input  logic                Mirror,
  output logic [ADDR_W-1:0]   MemAddr,
  output logic                MemRd,
  input  logic [DATA_W-1:0]   MemData,
  output logic [DATA_W-1:0]   WordOut,
  output logic                WordLoad,
  output logic [IDX_W-1:0]    WordIdx,
  output logic                Busy,
  output logic                Done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ROW_W - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(ROW_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] row_start_q, row_start_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [IDX_W-1:0]  tag_q [RD_LAT];
  logic [IDX_W-1:0]  tag_d [RD_LAT];
  logic [DATA_W-1:0] word_out_q, word_out_d;
  logic              word_load_q, word_load_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] start_addr;
  logic [IDX_W-1:0]  first_off;
  logic [IDX_W-1:0]  next_off;
  logic [DATA_W-1:0] cap_data;
  logic              tail_vld;
  logic [IDX_W-1:0]  tail_tag;
  logic              last_tail;

  // Row start wraps modulo 2^ADDR_W, like every address derived from it.
  assign start_addr = SpriteBase + ADDR_W'(Row) * ROW_STEP;

`ifdef SPRITE_FETCH_MIRROR_EN
  localparam int NPIX = DATA_W / PIX_W;

  logic mirror_q, mirror_d;

  function automatic logic [DATA_W-1:0] pix_rev(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < NPIX; k++) begin
      r[(NPIX-1-k)*PIX_W +: PIX_W] = w[k*PIX_W +: PIX_W];
    end
    return r;
  endfunction

  // A mirrored burst walks the row from its last word down to its first.
  assign first_off = Mirror ? LAST_IDX : '0;
  assign next_off  = mirror_q ? LAST_IDX - (cnt_q + 1'b1) : cnt_q + 1'b1;
  assign cap_data  = mirror_q ? pix_rev(MemData) : MemData;

  always_comb begin
    mirror_d = mirror_q;
    if (state_q == S_IDLE && Start) mirror_d = Mirror;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) mirror_q <= 1'b0;
    else         mirror_q <= mirror_d;
  end
`else
  logic [PIX_W-1:0] mirror_unused;
  assign mirror_unused = {PIX_W{Mirror}};

  assign first_off = '0;
  assign next_off  = cnt_q + 1'b1;
  assign cap_data  = MemData;
`endif

  assign tail_vld  = vld_q[RD_LAT-1];
  assign tail_tag  = tag_q[RD_LAT-1];
  assign last_tail = tail_vld && (tail_tag == LAST_IDX);

  // Valid/tag pipe mirrors the RAM latency; the tag is the word's output-order index.
  always_comb begin
    vld_d[0] = mem_rd_q;
    tag_d[0] = cnt_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    // NOTE: every _d gets its default before the case so no path can infer a latch.
    state_d     = state_q;
    row_start_d = row_start_q;
    cnt_d       = cnt_q;
    mem_addr_d  = '0;
    mem_rd_d    = 1'b0;
    word_out_d  = word_out_q;
    word_idx_d  = word_idx_q;
    word_load_d = tail_vld;
    done_d      = last_tail;

    if (tail_vld) begin
      word_out_d = cap_data;
      word_idx_d = tail_tag;
    end

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d     = S_ISSUE;
          row_start_d = start_addr;
          cnt_d       = '0;
          mem_rd_d    = 1'b1;
          mem_addr_d  = start_addr + ADDR_W'(first_off);
        end
      end
      S_ISSUE: begin
        // cnt_q is the sequence number of the read currently on MemAddr.
        if (cnt_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          mem_rd_d   = 1'b1;
          mem_addr_d = row_start_q + ADDR_W'(next_off);
        end
      end
      S_DRAIN: begin
        if (last_tail) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      row_start_q <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      vld_q       <= '0;
      word_out_q  <= '0;
      word_load_q <= 1'b0;
      word_idx_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_start_q <= row_start_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      vld_q       <= vld_d;
      word_out_q  <= word_out_d;
      word_load_q <= word_load_d;
      word_idx_q  <= word_idx_d;
      done_q      <= done_d;
    end
  end

  // NOTE: tags are only ever read when qualified by vld_q, so they are plain data flops without reset.
  always_ff @(posedge Clock) begin
    for (int i = 0; i < RD_LAT; i++) tag_q[i] <= tag_d[i];
  end

  assign MemAddr  = mem_addr_q;
  assign MemRd    = mem_rd_q;
  assign WordOut  = word_out_q;
  assign WordLoad = word_load_q;
  assign WordIdx  = word_idx_q;
  assign Busy     = (state_q != S_IDLE);
  assign Done     = done_q;

endmodule
